// File: rtl/mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_muldiv_unit
//   Iterative radix-2 HI/LO multiply/divide unit for the MIPS core.
//   Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring), one bit per
//   enabled clock, plus the MTHI/MTLO register writes.
//
//   Parameters
//     WIDTH  operand and HI/LO width (>= 4, even)
//     CNT_W  iteration counter width, derived from WIDTH (do not override)
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-low reset
//     clk_enable  when low, every register holds
//     start       issue strobe, accepted only while idle
//     op[2:0]     000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO,
//                 11x no-op
//     a, b        rs / rt operands
//     abort       (MULDIV_ABORT_EN only) flush an in-flight operation
//     busy        high while a mul/div is in flight (CALC or FIX)
//     done        one-cycle pulse after HI/LO take a mul/div result
//     hi, lo      architectural HI/LO registers
//
//   Build option
//     `define MULDIV_ABORT_EN adds the abort input.
//
//   Latency: accept edge E0, WIDTH CALC edges, FIX edge E0+WIDTH+1 writes
//   HI/LO and raises done for the following cycle.
// -----------------------------------------------------------------------------
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Magnitude of a two's-complement value. MIN maps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  // Multiply: {partial product high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0] prod_q,  prod_d;
  logic [WIDTH-1:0]   opnd_q,  opnd_d;   // multiplicand or divisor
  logic               is_div_q, is_div_d;
  logic               neg_q,   neg_d;    // negate product / quotient
  logic               neg_r_q, neg_r_d;  // negate remainder (dividend sign)
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               done_q,  done_d;

  // ---- one multiply step: conditional add, then shift right ----
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // ---- one restoring divide step ----
  // The shifted remainder is below 2*divisor, so after a successful subtract
  // the difference always fits in WIDTH bits and can be taken modulo 2^WIDTH.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = prod_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign div_next = rem_ge ? {rem_diff, prod_q[WIDTH-2:0], 1'b1}
                           : {prod_q[2*WIDTH-2:0], 1'b0};

  // ---- sign correction applied in FIX ----
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  assign mul_res = neg_q   ? -prod_q : prod_q;
  assign quo_res = neg_q   ? -prod_q[WIDTH-1:0]       : prod_q[WIDTH-1:0];
  assign rem_res = neg_r_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULTU, OP_MULT: begin
              state_d  = S_CALC;
              cnt_d    = '0;
              is_div_d = 1'b0;
              prod_d   = {{WIDTH{1'b0}}, op[0] ? mag(b) : b};
              opnd_d   = op[0] ? mag(a) : a;
              neg_d    = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_d  = 1'b0;
            end
            OP_DIVU, OP_DIV: begin
              state_d  = S_CALC;
              cnt_d    = '0;
              is_div_d = 1'b1;
              // Divide by zero runs as unsigned on the raw dividend: the
              // restoring loop then naturally yields quotient all-ones and
              // remainder equal to the dividend.
              if (op[0] && (b != '0)) begin
                prod_d  = {{WIDTH{1'b0}}, mag(a)};
                opnd_d  = mag(b);
                neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                neg_r_d = a[WIDTH-1];
              end else begin
                prod_d  = {{WIDTH{1'b0}}, a};
                opnd_d  = b;
                neg_d   = 1'b0;
                neg_r_d = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      S_CALC: begin
        prod_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef MULDIV_ABORT_EN
    // Flush: discard the in-flight result. Has no effect while idle, so a
    // start in the same cycle is still taken.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv_unit
//   Self-checking bench for mips_muldiv_unit (WIDTH=32). Directed vector
//   table, randomized ops against a plain-arithmetic reference model, and
//   hand-written sequences for MTHI/MTLO, issue-while-busy, clock-enable
//   stall, mid-operation reset and (when MULDIV_ABORT_EN is defined) abort.
// -----------------------------------------------------------------------------
module tb_mips_muldiv_unit;
  localparam int W = 32;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic         clk = 1'b0;
  logic         reset;
  logic         clk_enable;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_ABORT_EN
  logic         abort;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
`ifdef MULDIV_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, eh, el;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] pu;
    longint      sx, sy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0; el = '0;
    case (o)
      OP_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        eh = pu[63:32]; el = pu[31:0];
      end
      OP_MULT: begin
        p = sx * sy; pu = p;
        eh = pu[63:32]; el = pu[31:0];
      end
      OP_DIVU: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin el = x / y; eh = x % y; end
      end
      default: begin
        if (y == 0) begin eh = x; el = '1; end
        else begin
          q = sx / sy; r = sx % sy;   // truncating, remainder signed like dividend
          pu = q; el = pu[31:0];
          pu = r; eh = pu[31:0];
        end
      end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
  endtask

  // Counts edges until done is seen (bounded); busy must stay high until then.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = (busy === 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) return;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_check(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat;
    bit bok;
    issue(o, x, y);
    chk({nm, "_done_cleared"}, done, 0);
    wait_done(lat, bok);
    chk({nm, "_latency"}, lat, W + 1);
    chk({nm, "_busy_held"}, bok, 1);
    chk({nm, "_busy_low_at_done"}, busy, 0);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic [W-1:0] eh, el;
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    int lat, cnt;
    bit bok;

    tbl[0] = '{op: OP_MULTU, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, eh: 32'hFFFF_FFFE, el: 32'h0000_0001};
    tbl[1] = '{op: OP_MULT,  a: 32'hFFFF_FFFD, b: 32'd5,         eh: 32'hFFFF_FFFF, el: 32'hFFFF_FFF1};
    tbl[2] = '{op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'd2,         eh: 32'hFFFF_FFFF, el: 32'hFFFF_FFFD};
    tbl[3] = '{op: OP_DIVU,  a: 32'h0000_1234, b: 32'd0,         eh: 32'h0000_1234, el: 32'hFFFF_FFFF};
    tbl[4] = '{op: OP_DIV,   a: 32'h8000_0000, b: 32'hFFFF_FFFF, eh: 32'h0000_0000, el: 32'h8000_0000};
    tbl[5] = '{op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'd0,         eh: 32'hFFFF_FFF9, el: 32'hFFFF_FFFF};

    reset = 1'b0; clk_enable = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0;
`ifdef MULDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ---- MTHI / MTLO ----
    issue(OP_MTHI, 32'hCAFE_BABE, '0);
    chk("mthi_hi", hi, 32'hCAFE_BABE);
    chk("mthi_busy", busy, 0);
    chk("mthi_done", done, 0);
    issue(OP_MTLO, 32'h1234_5678, '0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi_kept", hi, 32'hCAFE_BABE);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);

    // ---- MTHI ignored while busy; HI/LO stale until FIX ----
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NOP;
    chk("busy_mthi_ignored_hi", hi, 32'hCAFE_BABE);
    chk("busy_lo_stale", lo, 32'h1234_5678);
    chk("busy_still_busy", busy, 1);
    wait_done(lat, bok);
    chk("busy_mthi_lat", lat, W - 3);
    chk("busy_mthi_res_hi", hi, 0);
    chk("busy_mthi_res_lo", lo, 12);
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);

    // ---- directed table, issued back-to-back in the done cycle ----
    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el);

    // ---- randomized ops against the reference model ----
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      model(ro, rx, ry, eh, el);
      run_check($sformatf("rand%0d_op%0d_%h_%h", i, ro, rx, ry), ro, rx, ry, eh, el);
    end
    @(posedge clk); #1;

    // ---- clk_enable stall mid-CALC ----
    issue(OP_MULTU, 32'd7, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    clk_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0) cnt++;
    end
    chk("stall_hold", cnt, 0);
    clk_enable = 1'b1;
    wait_done(lat, bok);
    chk("stall_enabled_edges", lat + 5, W + 1);
    chk("stall_hi", hi, 0);
    chk("stall_lo", lo, 42);
    @(posedge clk); #1;

    // ---- reset mid-operation ----
    issue(OP_MTHI, 32'h0000_55AA, '0);
    issue(OP_MULTU, 32'd7, 32'd6);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    chk("midrst_hi_after", hi, 0);
    chk("midrst_lo_after", lo, 0);

`ifdef MULDIV_ABORT_EN
    // ---- abort ----
    issue(OP_MTHI, 32'h0000_1111, '0);
    issue(OP_MTLO, 32'h0000_2222, '0);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 32'h0000_1111);
    chk("abort_lo", lo, 32'h0000_2222);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    run_check("abort_reissue", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    @(posedge clk); #1;
    abort = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7);
    abort = 1'b0;
    chk("abort_start_wins", busy, 1);
    wait_done(lat, bok);
    chk("abort_start_wins_lat", lat, W + 1);
    chk("abort_start_wins_lo", lo, 14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
